// File: rtl/masked_sbox_pkg.sv
// masked_sbox_pkg: shared defaults, FSM encoding and checksum step for the S-box table loader
package masked_sbox_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_RD_LAT = 2;
  localparam int CSUM_MAX_W = 64;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
  // rotate-left-by-one within the low w bits, then fold in the new word
  function automatic logic [CSUM_MAX_W-1:0] csum_step(input logic [CSUM_MAX_W-1:0] csum,
                                                      input logic [CSUM_MAX_W-1:0] data,
                                                      input int w);
    logic [CSUM_MAX_W-1:0] mask;
    mask = (CSUM_MAX_W'(1) << w) - CSUM_MAX_W'(1);
    return (((csum << 1) | (csum >> (w - 1))) & mask) ^ data;
  endfunction
endpackage

// File: rtl/sbox_csum_acc.sv
// sbox_csum_acc: registered rolling checksum with synchronous clear and per-word enable
module sbox_csum_acc
  import masked_sbox_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] csum
);
  logic [DATA_W-1:0] csum_q, csum_d;
  always_comb begin
    csum_d = clr ? '0 :
             en  ? DATA_W'(csum_step(CSUM_MAX_W'(csum_q), CSUM_MAX_W'(data), DATA_W)) : csum_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else csum_q <= csum_d;
  end
  assign csum = csum_q;
endmodule

// File: rtl/masked_sbox_table_loader.sv
// masked_sbox_table_loader: streams DEPTH words into one BRAM write port, reports a rolling checksum.
// LOADER_READBACK_EN adds a VERIFY pass that re-reads the table and flags a checksum mismatch.
module masked_sbox_table_loader
  import masked_sbox_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_di,
  input  logic [DATA_W-1:0] bram_do,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d, bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_di_q, bram_di_d;
  logic loaded_q, loaded_d, bram_en_q, bram_en_d, bram_we_q, bram_we_d;
  logic csum_clr, csum_en, beat, at_last, start_ok;
`ifdef LOADER_READBACK_EN
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d, rd_lpipe_q, rd_lpipe_d;
  logic fin_q, fin_d, error_q, error_d, rd_issue, rd_sample;
  logic [DATA_W-1:0] rd_csum;
`endif

  assign s_ready  = (state_q == LOAD) & ~loaded_q;
  assign beat     = s_valid & s_ready;
  assign at_last  = count_q == ADDR_W'(DEPTH - 1);
  assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));
  assign busy     = (state_q == LOAD) | (state_q == VERIFY);
  assign done     = state_q == DONE;

  // loaded_q marks "all addresses issued" for the current pass (writes in LOAD, reads in VERIFY)
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    loaded_d = loaded_q;
    bram_en_d = 1'b0;
    bram_we_d = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_di_d = bram_di_q;
    csum_clr = 1'b0;
    csum_en = 1'b0;
`ifdef LOADER_READBACK_EN
    error_d = error_q;
`endif
    if (abort) begin
      state_d = IDLE;
    end else if (start_ok) begin
      state_d = LOAD;
      count_d = '0;
      loaded_d = 1'b0;
      csum_clr = 1'b1;
`ifdef LOADER_READBACK_EN
      error_d = 1'b0;
`endif
    end else if (state_q == LOAD) begin
      if (beat) begin
        bram_en_d = 1'b1;
        bram_we_d = 1'b1;
        bram_addr_d = count_q;
        bram_di_d = s_data;
        csum_en = 1'b1;
        loaded_d = at_last;
        count_d = at_last ? count_q : count_q + ADDR_W'(1);
      end else if (loaded_q) begin
`ifdef LOADER_READBACK_EN
        state_d = VERIFY;
        count_d = '0;
        loaded_d = 1'b0;
`else
        state_d = DONE;
`endif
      end
    end
`ifdef LOADER_READBACK_EN
    else if (state_q == VERIFY) begin
      if (fin_q) begin
        error_d = rd_csum != checksum;
        state_d = DONE;
      end else if (!loaded_q) begin
        bram_en_d = 1'b1;
        bram_addr_d = count_q;
        loaded_d = at_last;
        count_d = at_last ? count_q : count_q + ADDR_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      loaded_q <= 1'b0;
      bram_en_q <= 1'b0;
      bram_we_q <= 1'b0;
      bram_addr_q <= '0;
      bram_di_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      loaded_q <= loaded_d;
      bram_en_q <= bram_en_d;
      bram_we_q <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_di_q <= bram_di_d;
    end
  end

  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_di   = bram_di_q;

  sbox_csum_acc #(.DATA_W(DATA_W)) u_ld_acc (
    .clk (clk),
    .rst (rst),
    .clr (csum_clr),
    .en  (csum_en),
    .data(s_data),
    .csum(checksum)
  );

`ifdef LOADER_READBACK_EN
  // read valid travels RD_LAT stages alongside a marker for the final address
  assign rd_issue   = bram_en_q & ~bram_we_q & (state_q == VERIFY);
  assign rd_pipe_d  = RD_LAT'({rd_pipe_q, rd_issue});
  assign rd_lpipe_d = RD_LAT'({rd_lpipe_q, rd_issue & (bram_addr_q == ADDR_W'(DEPTH - 1))});
  assign rd_sample  = rd_pipe_q[RD_LAT-1] & (state_q == VERIFY);
  assign fin_d      = rd_lpipe_q[RD_LAT-1] & (state_q == VERIFY) & ~abort;
  assign error      = error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe_q <= '0;
      rd_lpipe_q <= '0;
      fin_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      rd_pipe_q <= rd_pipe_d;
      rd_lpipe_q <= rd_lpipe_d;
      fin_q <= fin_d;
      error_q <= error_d;
    end
  end

  sbox_csum_acc #(.DATA_W(DATA_W)) u_rd_acc (
    .clk (clk),
    .rst (rst),
    .clr (csum_clr),
    .en  (rd_sample),
    .data(bram_do),
    .csum(rd_csum)
  );
`else
  logic unused_do;
  assign unused_do = ^bram_do ^ (RD_LAT > 0);
  assign error = 1'b0;
`endif
endmodule
